// File: rtl/mux_rr_arb.sv
// mux_rr_arb
//   N-channel registered multiplexer with per-channel valid/ready handshakes
//   and a built-in arbiter (round-robin or fixed priority). Several producer
//   streams are merged into one consumer stream. The chosen beat is captured
//   in a single output register together with the index of its source.
//
// Parameters
//   WIDTH     data width per channel (>= 1)
//   CHANNELS  number of input channels (power of two, >= 2)
//   SEL_W     select width, log2(CHANNELS)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_ready   per-channel accept (combinational, at most one bit set)
//   mode       0 = round-robin, 1 = fixed priority (lowest index wins)
//   out_data   registered selected data
//   out_sel    index of the channel that supplied out_data
//   out_valid  output beat valid
//   out_ready  consumer accept
module mux_rr_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] idx;
  logic             grant_valid;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new beat when it is empty or being drained.
  assign load = !out_valid || out_ready;

  // Arbitration. In round-robin the search starts one past the last granted
  // channel; because CHANNELS is a power of two the SEL_W-bit sum wraps
  // naturally. In fixed priority the search simply starts at channel 0.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = mode ? SEL_W'(i) : last + SEL_W'(i + 1);
      if (!grant_valid && in_valid[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

  assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

  // Only the granted channel sees ready, and only when the output can load.
  // rst_n gating keeps every ready low while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer. last starts at the top channel
  // so that channel 0 has first priority after reset. When loading with no
  // valid input only out_valid drops; data and sel keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb
//   Directed and randomized checks for mux_rr_arb with CHANNELS=4, WIDTH=8.
//   Directed steps cover reset, round-robin order, fixed priority, idle,
//   sparse wrap-around, backpressure and asynchronous reset mid-beat; a
//   randomized phase compares against a small behavioural arbiter model and
//   an in-order scoreboard.
module tb_mux_rr_arb;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;

  int checks = 0;
  int fails  = 0;

  logic [WIDTH-1:0] chanData [CHANNELS] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [CHANNELS*WIDTH-1:0] fixedData = {8'h43, 8'h32, 8'h21, 8'h10};

  mux_rr_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all data-path inputs in one go.
  task automatic applyStimulus(input logic [CHANNELS-1:0] valid,
                               input logic [CHANNELS*WIDTH-1:0] data,
                               input logic md, input logic ordy);
    in_valid  = valid;
    in_data   = data;
    mode      = md;
    out_ready = ordy;
  endtask

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [SEL_W-1:0] sel,
                           input logic [WIDTH-1:0] data);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sel"},   32'(out_sel),   32'(sel));
    checkOutput({tag, "_data"},  32'(out_data),  32'(data));
  endtask

  // Behavioural arbiter: first valid channel counted from last+1 (round
  // robin) or from channel 0 (fixed priority); -1 when nothing is valid.
  function automatic int modelGrant(input logic [CHANNELS-1:0] v,
                                    input logic md, input int lst);
    for (int off = 1; off <= CHANNELS; off++) begin
      int ch;
      ch = md ? off - 1 : (lst + off) % CHANNELS;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  initial begin
    int mLast;
    bit mValid;
    int g;
    logic [CHANNELS-1:0] expReady;
    logic [SEL_W+WIDTH-1:0] sb [$];
    logic [SEL_W+WIDTH-1:0] head;

    // Reset with all channels requesting: nothing may be accepted.
    rst_n = 1'b0;
    applyStimulus('1, fixedData, 1'b0, 1'b1);
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data",  32'(out_data),  32'd0);
    checkOutput("rst_sel",   32'(out_sel),   32'd0);
    checkOutput("rst_ready", 32'(in_ready),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Round-robin with every channel valid: 0,1,2,3,0 back to back.
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_ready", 32'(in_ready), 32'(1 << (k % CHANNELS)));
      tick();
      checkBeat("rr", SEL_W'(k % CHANNELS), chanData[k % CHANNELS]);
    end

    // Fixed priority: channel 1 wins repeatedly over channel 3.
    applyStimulus(4'b1010, fixedData, 1'b1, 1'b1);
    #1;
    checkOutput("fp_ready", 32'(in_ready), 32'b0010);
    tick();
    checkBeat("fp1a", 2'd1, 8'h21);
    tick();
    checkBeat("fp1b", 2'd1, 8'h21);
    applyStimulus(4'b1000, fixedData, 1'b1, 1'b1);
    #1;
    checkOutput("fp3_ready", 32'(in_ready), 32'b1000);
    tick();
    checkBeat("fp3", 2'd3, 8'h43);

    // Idle: valid drops, data and sel hold.
    applyStimulus(4'b0000, fixedData, 1'b0, 1'b1);
    tick();
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_sel",   32'(out_sel),   32'd3);
    checkOutput("idle_data",  32'(out_data),  32'h43);

    // Sparse round-robin wrap from last=3: grants 2, 3, 0.
    applyStimulus(4'b0100, fixedData, 1'b0, 1'b1);
    tick();
    checkBeat("wrap2", 2'd2, 8'h32);
    applyStimulus(4'b1001, fixedData, 1'b0, 1'b1);
    #1;
    checkOutput("wrap3_ready", 32'(in_ready), 32'b1000);
    tick();
    checkBeat("wrap3", 2'd3, 8'h43);
    checkOutput("wrap0_ready", 32'(in_ready), 32'b0001);
    tick();
    checkBeat("wrap0", 2'd0, 8'h10);

    // Backpressure for three cycles, then drain and load at the same edge.
    applyStimulus('1, fixedData, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBeat("bp_hold", 2'd0, 8'h10);
      checkOutput("bp_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus('1, fixedData, 1'b0, 1'b1);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    checkBeat("bp_release", 2'd1, 8'h21);

    // Asynchronous reset while a beat is held.
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_data",  32'(out_data),  32'd0);
    checkOutput("arst_sel",   32'(out_sel),   32'd0);
    checkOutput("arst_ready", 32'(in_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("arst_first_ready", 32'(in_ready), 32'b0001);
    tick();
    checkBeat("arst_first", 2'd0, 8'h10);

    // Randomized phase against a model and scoreboard. The DUT now holds
    // channel 0's beat with last=0 and round-robin mode.
    mLast  = 0;
    mValid = 1'b1;
    sb.push_back({2'd0, 8'h10});
    mode   = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      applyStimulus(CHANNELS'($urandom_range(0, 15)), CHANNELS*WIDTH'($urandom),
                    ($urandom_range(0, 15) == 0) ? ~mode : mode,
                    $urandom_range(0, 3) != 0);
      #1;
      checkOutput("rnd_valid", 32'(out_valid), 32'(mValid));
      // Output handshake: the beat must be the oldest accepted one.
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rnd_sb_empty", 32'd1, 32'd0);
        end else begin
          head = sb.pop_front();
          checkOutput("rnd_out_sel",  32'(out_sel),  32'(head[SEL_W+WIDTH-1:WIDTH]));
          checkOutput("rnd_out_data", 32'(out_data), 32'(head[WIDTH-1:0]));
        end
      end
      g = modelGrant(in_valid, mode, mLast);
      expReady = '0;
      if ((!mValid || out_ready) && g >= 0) expReady[g] = 1'b1;
      checkOutput("rnd_ready", 32'(in_ready), 32'(expReady));
      if (!mValid || out_ready) begin
        if (g >= 0) begin
          sb.push_back({SEL_W'(g), in_data[g*WIDTH +: WIDTH]});
          mValid = 1'b1;
          mLast  = g;
        end else begin
          mValid = 1'b0;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
